// File: rtl/mem_copy_engine_if.sv
// Bus bundle for mem_copy_engine: the control/status handshake together with
// the data-memory initiator and responder signals.
interface mem_copy_engine_if;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;

    // The copy engine: takes commands, drives the memory request.
    modport master (
        input  start, src_addr, dst_addr, word_count, read_data, clk_stall,
        output busy, done, err, addr, write_data, memread, memwrite, sign_mask
    );

    // The environment: issues commands and answers memory requests.
    modport slave (
        output start, src_addr, dst_addr, word_count, read_data, clk_stall,
        input  busy, done, err, addr, write_data, memread, memwrite, sign_mask
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine. Each word is read from the source address,
// held in a data register and written to the destination address. Memory
// accesses may be stretched by clk_stall; a bounded stall counter turns a hung
// access into an error instead of a lock-up.
module mem_copy_engine #(
    parameter logic [3:0] WORD_MASK = 4'b1111,
    parameter int         TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_copy_engine_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [31:0]       src_q, src_n;
    logic [31:0]       dst_q, dst_n;
    logic [15:0]       count_q, count_n;
    logic [31:0]       data_q, data_n;
    logic [CNT_W-1:0]  stall_cnt, stall_n;
    logic              err_q, err_n;

    logic              mem_read;
    logic              mem_write;
    logic              misaligned;

    assign misaligned = (bus.src_addr[1:0] != 2'b00) || (bus.dst_addr[1:0] != 2'b00);

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            count_q   <= '0;
            data_q    <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            src_q     <= src_n;
            dst_q     <= dst_n;
            count_q   <= count_n;
            data_q    <= data_n;
            stall_cnt <= stall_n;
            err_q     <= err_n;
        end
    end

    // Next-state logic: sequences read/write pairs, advances pointers and
    // abandons an access whose stall run reaches the limit.
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        count_n = count_q;
        data_n  = data_q;
        stall_n = stall_cnt;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (misaligned) begin
                        err_n = 1'b1;
                    end else begin
                        src_n   = bus.src_addr;
                        dst_n   = bus.dst_addr;
                        count_n = bus.word_count;
                        stall_n = '0;
                        state_n = (bus.word_count == 16'd0) ? FIN : RD_REQ;
                    end
                end
            end

            RD_REQ: begin
                stall_n = '0;
                state_n = RD_WAIT;
            end

            RD_WAIT: begin
                if (!bus.clk_stall) begin
                    data_n  = bus.read_data;
                    state_n = WR_REQ;
                end else if (stall_cnt == STALL_LIMIT) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall_n = stall_cnt + 1'b1;
                end
            end

            WR_REQ: begin
                stall_n = '0;
                state_n = WR_WAIT;
            end

            WR_WAIT: begin
                if (!bus.clk_stall) begin
                    src_n   = src_q + 32'd4;
                    dst_n   = dst_q + 32'd4;
                    count_n = count_q - 16'd1;
                    state_n = (count_q == 16'd1) ? FIN : RD_REQ;
                end else if (stall_cnt == STALL_LIMIT) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall_n = stall_cnt + 1'b1;
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output decode: the memory request follows the state, so it is zero in
    // IDLE/FIN and during reset without any extra gating.
    always_comb begin
        mem_read       = (state == RD_REQ) || (state == RD_WAIT);
        mem_write      = (state == WR_REQ) || (state == WR_WAIT);
        bus.memread    = mem_read;
        bus.memwrite   = mem_write;
        bus.addr       = mem_read ? src_q : (mem_write ? dst_q : 32'd0);
        bus.write_data = mem_write ? data_q : 32'd0;
        bus.sign_mask  = (mem_read || mem_write) ? WORD_MASK : 4'b0000;
        bus.busy       = mem_read || mem_write;
        bus.done       = (state == FIN);
        bus.err        = err_q;
    end

    // Read and write requests are mutually exclusive by construction.
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));

    // A pulse on done and one on err never coincide.
    assert property (@(posedge clk) disable iff (!rst_n) !(bus.done && bus.err));

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter WORD_MASK, default 4'b1111, which is the sign_mask value driven on every access (full-word).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, which is the maximum number of consecutive stalled cycles allowed per access before an error.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 The block SHALL provide control port start  in  1  single-cycle request to begin a copy.
REQ-005 The block SHALL provide control port src_addr  in  32  word-aligned source byte address, sampled on start.
REQ-006 The block SHALL provide control port dst_addr  in  32  word-aligned destination byte address, sampled on start.
REQ-007 The block SHALL provide control port word_count  in  16  number of 32-bit words to copy, sampled on start.
REQ-008 The block SHALL provide status port busy  out  1  high from the cycle after an accepted start until done or err.
REQ-009 The block SHALL provide status ports done  out  1  and err  out  1, each a one-cycle completion pulse.
REQ-010 The block SHALL provide data-memory initiator ports addr  out  32, write_data  out  32, memwrite  out  1, memread  out  1 and sign_mask  out  4.
REQ-011 The block SHALL provide data-memory responder inputs read_data  in  32 and clk_stall  in  1, where clk_stall high means the access is in progress.

Function
REQ-012 The block SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and FIN.
REQ-013 In IDLE with start=1, the block SHALL latch src, dst and count, then go to RD_REQ; if count=0 it SHALL go to FIN with no access.
REQ-014 In IDLE with start=1 and src[1:0]!=0 or dst[1:0]!=0, the block SHALL make no access and pulse err for one cycle the next cycle.
REQ-015 RD_REQ SHALL last exactly one cycle with memread=1 and addr=current src, then go to RD_WAIT.
REQ-016 In RD_WAIT the block SHALL hold memread=1 and addr stable; on the first edge with clk_stall=0 it SHALL capture read_data into a data register and go to WR_REQ.
REQ-017 WR_REQ SHALL last one cycle with memwrite=1, addr=current dst and write_data=captured word, then go to WR_WAIT.
REQ-018 In WR_WAIT the block SHALL hold memwrite, addr and write_data stable until clk_stall=0, then go to either FIN or RD_REQ.
REQ-019 On leaving WR_WAIT the block SHALL increment src and dst by 4 (modulo 2^32, wrap allowed), decrement count, and go to FIN if the new count is 0, else to RD_REQ.
REQ-020 memread and memwrite SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and FIN.
REQ-021 sign_mask SHALL equal WORD_MASK whenever memread or memwrite is high, and 0 otherwise.
REQ-022 FIN SHALL last one cycle, pulse done=1, deassert busy and return to IDLE.
REQ-023 The block SHALL keep a stall counter that resets on each REQ state; if it reaches TIMEOUT in a WAIT state, the block SHALL drop the request, pulse err and return to IDLE without asserting done.
REQ-024 start while busy SHALL be ignored, with no effect on latched parameters.
REQ-025 With clk_stall held low throughout, each word SHALL take exactly 4 cycles, so an N-word copy asserts done 4N+1 cycles after start.

Reset
REQ-026 While rst_n=0 the block SHALL asynchronously force the state to IDLE and drive addr, write_data, memread, memwrite, sign_mask, busy, done and err to 0, clearing all internal registers.
REQ-027 If reset is asserted mid-copy, the block SHALL abandon the transfer with no done or err pulse after release, and start SHALL be accepted on the first edge after rst_n rises.

Verification
REQ-028 The bench SHALL drive src=0x100, dst=0x200, count=3 with no stall -> reads at 0x100/0x104/0x108 and writes at 0x200/0x204/0x208 of the read data, done at cycle 13, busy low after.
REQ-029 The bench SHALL drive count=1 with clk_stall high for 5 cycles in RD_WAIT -> memread and addr stay stable for all 5 cycles, data is captured on the first low cycle, and a single write follows.
REQ-030 The bench SHALL drive src=0x102 -> no memread or memwrite, err pulse the next cycle, busy stays 0.
REQ-031 The bench SHALL hold clk_stall high forever with TIMEOUT=255 -> err pulses after 255 stalled cycles and memread drops.
REQ-032 The bench SHALL drive src=0xFFFFFFFC with count=2 -> the second read is at 0x00000000.
REQ-033 The bench SHALL assert rst_n=0 in WR_WAIT -> all outputs are 0 immediately, no done pulse occurs, and a fresh start succeeds.
